snf_rxreq: RTL and testbench
============================

// Module: snf_rxreq
// PURPOSE
//  SN-F receive side of the CHI REQ channel: accepts REQ flits sent by the HN-F TXREQ link.
//  Issues L-credits, buffers accepted flits in a FIFO, and presents them to the SN-F memory
//  pipeline over a valid/ready interface. Never grants a credit it cannot back with buffer
//  space. Absorbs link-credit-return flits (ReqLCrdReturn, Opcode 6'h00).
// PARAMETERS
//  DEPTH    4  request FIFO entries (power of two, >=2)
//  MAX_CRD  4  max L-credits outstanding at the transmitter (1..15, <= DEPTH)
// PORTS
//  clock          in   1     single clock, all state on posedge
//  reset          in   1     asynchronous, active-high; clears all state
//  RXREQFLIT      in   reqflit_t  incoming REQ flit
//  RXREQFLITV     in   1     flit valid; legal only while transmitter holds a credit
//  RXREQFLITPEND  in   1     early flit indication; informational, no effect on state
//  RXREQLCRDV     out  1     one-cycle pulse = one L-credit granted (registered)
//  req_valid      out  1     FIFO head valid toward memory pipeline
//  req_flit       out  reqflit_t  FIFO head flit (stable while req_valid & !req_ready)
//  req_ready      in   1     downstream accepts head when req_valid & req_ready
//  crd_err        out  1     sticky: flit arrived with zero credits outstanding
//  occupancy      out  $clog2(DEPTH+1)  current FIFO entry count
// BEHAVIOUR
//  Reset values: RXREQLCRDV=0, req_valid=0, req_flit='0, crd_err=0, occupancy=0, crd_q=0.
//  crd_q ($clog2(MAX_CRD+1) bits) = credits granted and not yet consumed.
//  Credit grant: lcrdv_d = ((count_q + crd_q + RXREQLCRDV) < DEPTH) &&
//    ((crd_q + RXREQLCRDV) < MAX_CRD); RXREQLCRDV <= lcrdv_d. Same-cycle dequeue is NOT
//    credited early (conservative; freed slot credited the following cycle).
//  crd_q update per edge: +1 if RXREQLCRDV, -1 if RXREQFLITV && crd_q!=0; both -> unchanged.
//    Transmitter may not use a credit in the cycle it is granted: RXREQFLITV with crd_q==0
//    is an error even if RXREQLCRDV=1 that cycle.
//  Flit with RXREQFLITV && crd_q==0: dropped (no enqueue, crd_q unchanged), crd_err<=1,
//    stays 1 until reset.
//  Flit with crd_q!=0 and Opcode==6'h00 (ReqLCrdReturn): consumes credit, not enqueued.
//  Any other legal flit: enqueued at tail; count_q+1.
//  Latency: flit valid in cycle N is visible at req_valid/req_flit in cycle N+1 (empty FIFO).
//  Dequeue when req_valid & req_ready: head advances, count_q-1. Enqueue+dequeue same cycle:
//    count_q unchanged, both pointers advance; legal at full since credit rule guarantees
//    count_q+crd_q<=DEPTH, so enqueue at full cannot occur legally (if it does via crd_err
//    path it is already dropped).
//  Pointers $clog2(DEPTH) bits, wrap modulo DEPTH. Order strictly FIFO; flit fields
//    passed through unmodified.
//  Invariant (assert): count_q + crd_q <= DEPTH; crd_q <= MAX_CRD.
//  Reset mid-operation: FIFO contents, outstanding credits and crd_err discarded; after
//    deassertion credits re-issued from zero as at power-up.
// TESTING
//  1 Reset then idle, req_ready=1 -> RXREQLCRDV high cycles 1..4 after reset release
//    (4 pulses total), then low; crd_q=4.
//  2 Send ReadNoSnp Addr=48'h1000 TxnID=8'h05 SrcID=7'h01, req_ready=0 -> req_valid next
//    cycle, fields identical, held 10 cycles; no new credit; ready=1 -> one LCRDV pulse
//    the cycle after the dequeue cycle.
//  3 Four back-to-back flits TxnID 0..3, req_ready=0 -> occupancy=4, LCRDV stays 0;
//    release ready -> TxnID 0,1,2,3 in order, 4 credits returned, pointers wrapped.
//  4 Flit Opcode=6'h00 with credits held -> occupancy unchanged, crd_q 4->3, one LCRDV
//    pulse next cycle, crd_q back to 4.
//  5 Exhaust credits, then extra flit -> crd_err=1 sticky, occupancy unchanged, no
//    req_valid for that flit; cleared only by reset.
//  6 Assert reset asynchronously with 2 entries queued and 2 credits outstanding ->
//    outputs zero immediately (no clock edge); after release behaviour matches test 1.

Source files
------------

// File: rtl/snf_rxreq.sv
// SN-F receive side of the CHI REQ channel: grants L-credits backed by FIFO space,
// buffers accepted REQ flits and hands them to the memory pipeline over valid/ready.
package snf_rxreq_pkg;
    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [7:0]  txn_id;
        logic [5:0]  opcode;
        logic [2:0]  size;
        logic [47:0] addr;
    } reqflit_t;

    localparam logic [5:0] OPC_LCRD_RETURN = 6'h00;
endpackage

module snf_rxreq
    import snf_rxreq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_CRD = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  reqflit_t                   RXREQFLIT,
    input  logic                       RXREQFLITV,
    input  logic                       RXREQFLITPEND,
    output logic                       RXREQLCRDV,
    output logic                       req_valid,
    output reqflit_t                   req_flit,
    input  logic                       req_ready,
    output logic                       crd_err,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(MAX_CRD + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + MAX_CRD + 2);

    logic [CW-1:0] count_reg, count_next;
    logic [RW-1:0] crd_reg, crd_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          lcrdv_reg, lcrdv_next;
    logic          crd_err_reg, crd_err_next;

    reqflit_t      mem [DEPTH];

    logic          flit_legal;
    logic          flit_illegal;
    logic          enq;
    logic          deq;
    logic [SW-1:0] outstanding;
    logic [SW-1:0] committed;
    logic          unused_pend;

    // The early-flit hint carries no state in this receiver.
    assign unused_pend = RXREQFLITPEND;

    // A credit granted this cycle cannot be used this cycle, so only crd_reg qualifies a flit.
    assign flit_legal   = RXREQFLITV && (crd_reg != '0);
    assign flit_illegal = RXREQFLITV && (crd_reg == '0);
    assign enq          = flit_legal && (RXREQFLIT.opcode != OPC_LCRD_RETURN);
    assign req_valid    = (count_reg != '0);
    assign deq          = req_valid && req_ready;

    assign req_flit   = req_valid ? mem[rd_ptr_reg] : '0;
    assign RXREQLCRDV = lcrdv_reg;
    assign crd_err    = crd_err_reg;
    assign occupancy  = count_reg;

    // In-flight pulse counts as outstanding; a same-cycle dequeue is credited one cycle later.
    always_comb begin
        outstanding = SW'(crd_reg) + SW'(lcrdv_reg);
        committed   = SW'(count_reg) + outstanding;
        lcrdv_next  = (committed < SW'(DEPTH)) && (outstanding < SW'(MAX_CRD));
    end

    always_comb begin
        crd_next = crd_reg;
        if (lcrdv_reg && !flit_legal) begin
            crd_next = crd_reg + RW'(1);
        end else if (!lcrdv_reg && flit_legal) begin
            crd_next = crd_reg - RW'(1);
        end

        count_next = count_reg;
        if (enq && !deq) begin
            count_next = count_reg + CW'(1);
        end else if (deq && !enq) begin
            count_next = count_reg - CW'(1);
        end

        wr_ptr_next  = enq ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next  = deq ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        crd_err_next = crd_err_reg | flit_illegal;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            crd_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            lcrdv_reg   <= 1'b0;
            crd_err_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            crd_reg     <= crd_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            lcrdv_reg   <= lcrdv_next;
            crd_err_reg <= crd_err_next;
        end
    end

    // Storage needs no reset: entries are only observed while counted as occupied.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_ptr_reg] <= RXREQFLIT;
        end
    end

    a_no_overcommit: assert property (@(posedge clock) disable iff (reset)
        (int'(count_reg) + int'(crd_reg) <= DEPTH));
    a_crd_bound: assert property (@(posedge clock) disable iff (reset)
        (int'(crd_reg) <= MAX_CRD));

endmodule

// File: tb/tb_snf_rxreq.sv
// Scenario bench for snf_rxreq: credit ramp, single/back-to-back flits, credit return,
// credit error and asynchronous reset, with a queue scoreboard on the dequeue side.
module tb_snf_rxreq;
    import snf_rxreq_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    reqflit_t   RXREQFLIT = '0;
    logic       RXREQFLITV = 1'b0;
    logic       RXREQFLITPEND = 1'b0;
    logic       RXREQLCRDV;
    logic       req_valid;
    reqflit_t   req_flit;
    logic       req_ready = 1'b0;
    logic       crd_err;
    logic [2:0] occupancy;

    int         checks = 0;
    int         failures = 0;
    int         grants = 0;
    reqflit_t   sb[$];

    snf_rxreq #(.DEPTH(4), .MAX_CRD(4)) dut (
        .clock(clock), .reset(reset),
        .RXREQFLIT(RXREQFLIT), .RXREQFLITV(RXREQFLITV), .RXREQFLITPEND(RXREQFLITPEND),
        .RXREQLCRDV(RXREQLCRDV), .req_valid(req_valid), .req_flit(req_flit),
        .req_ready(req_ready), .crd_err(crd_err), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (RXREQLCRDV) grants++;
    endtask

    function automatic reqflit_t mk(input logic [5:0] opc, input logic [47:0] addr,
                                    input logic [7:0] txn, input logic [6:0] src);
        reqflit_t f;
        f = '0;
        f.opcode = opc;
        f.addr   = addr;
        f.txn_id = txn;
        f.src_id = src;
        f.tgt_id = 7'h21;
        f.size   = 3'd6;
        f.qos    = 4'h3;
        return f;
    endfunction

    task automatic send(input reqflit_t f, input bit expect_enq);
        RXREQFLIT     = f;
        RXREQFLITV    = 1'b1;
        RXREQFLITPEND = 1'b1;
        if (expect_enq) sb.push_back(f);
        $display("send   opc=%0h txn=%0h addr=%0h", f.opcode, f.txn_id, f.addr);
        tick();
        RXREQFLITV    = 1'b0;
        RXREQFLITPEND = 1'b0;
        RXREQFLIT     = '0;
    endtask

    task automatic test_credit_ramp(input string tag);
        int g0;
        reset = 1'b0;
        g0 = grants;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (RXREQLCRDV !== (i <= 4)) begin
                failures++;
                $display("FAIL %s_lcrdv_c%0d: got %b required %b", tag, i, RXREQLCRDV, (i <= 4));
            end
        end
        checks++;
        if (grants - g0 != 4) begin
            failures++;
            $display("FAIL %s_grants: got %0d required 4", tag, grants - g0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({RXREQLCRDV, req_valid, crd_err} !== 3'b000 || occupancy !== 3'd0 || req_flit !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got lcrdv=%b valid=%b err=%b occ=%0d flit=%h required all zero",
                     RXREQLCRDV, req_valid, crd_err, occupancy, req_flit);
        end
        test_credit_ramp("reset");
    endtask

    task automatic test_single();
        reqflit_t f;
        int g0;
        req_ready = 1'b0;
        f = mk(6'h04, 48'h1000, 8'h05, 7'h01);
        send(f, 1'b1);
        checks++;
        if (req_valid !== 1'b1 || req_flit !== f || occupancy !== 3'd1) begin
            failures++;
            $display("FAIL single_latency: got valid=%b occ=%0d flit=%h required 1/1/%h",
                     req_valid, occupancy, req_flit, f);
        end
        g0 = grants;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (req_valid !== 1'b1 || req_flit !== f || RXREQLCRDV !== 1'b0) begin
                failures++;
                $display("FAIL single_hold_c%0d: got valid=%b lcrdv=%b flit=%h required 1/0/%h",
                         i, req_valid, RXREQLCRDV, req_flit, f);
            end
        end
        req_ready = 1'b1;
        f = sb.pop_front();
        $display("dequeue txn=%0h addr=%0h", req_flit.txn_id, req_flit.addr);
        tick();
        checks++;
        if (req_valid !== 1'b0 || RXREQLCRDV !== 1'b0) begin
            failures++;
            $display("FAIL single_deq: got valid=%b lcrdv=%b required 0/0", req_valid, RXREQLCRDV);
        end
        tick();
        checks++;
        if (RXREQLCRDV !== 1'b1) begin
            failures++;
            $display("FAIL single_credit_back: got %b required 1", RXREQLCRDV);
        end
        tick();
        checks++;
        if (RXREQLCRDV !== 1'b0 || grants - g0 != 1) begin
            failures++;
            $display("FAIL single_credit_once: got lcrdv=%b grants=%0d required 0/1",
                     RXREQLCRDV, grants - g0);
        end
    endtask

    task automatic test_back_to_back();
        reqflit_t exp;
        int g0;
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(6'h04, 48'h2000 + 48'(i * 64), 8'(i), 7'h01), 1'b1);
        g0 = grants;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (occupancy !== 3'd4 || RXREQLCRDV !== 1'b0) begin
                failures++;
                $display("FAIL b2b_full_c%0d: got occ=%0d lcrdv=%b required 4/0", i, occupancy, RXREQLCRDV);
            end
            tick();
        end
        req_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: got txn=%0h required no entry", req_flit.txn_id);
                end else begin
                    exp = sb.pop_front();
                    if (req_flit !== exp) begin
                        failures++;
                        $display("FAIL b2b_order: got txn=%0h flit=%h required txn=%0h flit=%h",
                                 req_flit.txn_id, req_flit, exp.txn_id, exp);
                    end
                end
                $display("dequeue txn=%0h addr=%0h", req_flit.txn_id, req_flit.addr);
            end
            tick();
        end
        checks++;
        if (sb.size() != 0 || occupancy !== 3'd0 || grants - g0 != 4) begin
            failures++;
            $display("FAIL b2b_drain: got left=%0d occ=%0d grants=%0d required 0/0/4",
                     sb.size(), occupancy, grants - g0);
        end
    endtask

    task automatic test_lcrd_return();
        send(mk(6'h00, 48'h0, 8'h00, 7'h01), 1'b0);
        checks++;
        if (occupancy !== 3'd0 || req_valid !== 1'b0 || RXREQLCRDV !== 1'b0) begin
            failures++;
            $display("FAIL lcrd_absorb: got occ=%0d valid=%b lcrdv=%b required 0/0/0",
                     occupancy, req_valid, RXREQLCRDV);
        end
        tick();
        checks++;
        if (RXREQLCRDV !== 1'b1) begin
            failures++;
            $display("FAIL lcrd_regrant: got %b required 1", RXREQLCRDV);
        end
        tick();
        checks++;
        if (RXREQLCRDV !== 1'b0) begin
            failures++;
            $display("FAIL lcrd_single_pulse: got %b required 0", RXREQLCRDV);
        end
    endtask

    task automatic test_crd_err();
        reqflit_t exp;
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(6'h04, 48'h3000 + 48'(i * 64), 8'h10 + 8'(i), 7'h02), 1'b1);
        checks++;
        if (crd_err !== 1'b0 || occupancy !== 3'd4) begin
            failures++;
            $display("FAIL err_before: got err=%b occ=%0d required 0/4", crd_err, occupancy);
        end
        send(mk(6'h04, 48'hDEAD00, 8'hEE, 7'h02), 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (crd_err !== 1'b1 || occupancy !== 3'd4) begin
                failures++;
                $display("FAIL err_sticky_c%0d: got err=%b occ=%0d required 1/4", i, crd_err, occupancy);
            end
            tick();
        end
        req_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL err_dropped: got txn=%0h required no entry", req_flit.txn_id);
                end else begin
                    exp = sb.pop_front();
                    if (req_flit !== exp) begin
                        failures++;
                        $display("FAIL err_order: got txn=%0h required txn=%0h", req_flit.txn_id, exp.txn_id);
                    end
                end
                $display("dequeue txn=%0h addr=%0h", req_flit.txn_id, req_flit.addr);
            end
            tick();
        end
        checks++;
        if (sb.size() != 0 || crd_err !== 1'b1 || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL err_after_drain: got left=%0d err=%b occ=%0d required 0/1/0",
                     sb.size(), crd_err, occupancy);
        end
    endtask

    task automatic test_async_reset();
        req_ready = 1'b0;
        send(mk(6'h04, 48'h4000, 8'h20, 7'h03), 1'b1);
        send(mk(6'h04, 48'h4040, 8'h21, 7'h03), 1'b1);
        checks++;
        if (occupancy !== 3'd2 || req_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup: got occ=%0d valid=%b required 2/1", occupancy, req_valid);
        end
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({RXREQLCRDV, req_valid, crd_err} !== 3'b000 || occupancy !== 3'd0 || req_flit !== '0) begin
            failures++;
            $display("FAIL arst_immediate: got lcrdv=%b valid=%b err=%b occ=%0d flit=%h required all zero",
                     RXREQLCRDV, req_valid, crd_err, occupancy, req_flit);
        end
        repeat (2) tick();
        req_ready = 1'b1;
        test_credit_ramp("arst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lcrd_return();
        test_crd_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
